// File: rtl/dpram_reader.sv
// dpram_reader
//
// Read-side sequencer for a dpram instance. A start command walks a
// contiguous, wrapping address range, issues one read per word and hides
// the RAM's one-cycle read latency. Samples leave on a valid/ready stream.
// The stream supports full backpressure and carries one sample per clock
// when the sink never stalls.
//
// Ports
//   ck, rst_n            clock (rising edge), asynchronous active-low reset
//   start, base, len     command strobe, first address, word count (0..SIZE);
//                        these are sampled only while idle
//   busy, done           command in progress, one-cycle completion pulse
//   re, raddr, rdata     dpram read port (rdata valid the cycle after re)
//   out_valid/out_ready  output stream handshake
//   out_data, out_last   sample and final-sample marker
module dpram_reader #(
  parameter int BITS   = 16,
  parameter int SIZE   = 256,
  parameter int AWIDTH = $clog2(SIZE)
) (
  input  logic              ck,
  input  logic              rst_n,
  input  logic              start,
  input  logic [AWIDTH-1:0] base,
  input  logic [AWIDTH:0]   len,
  output logic              busy,
  output logic              done,
  output logic              re,
  output logic [AWIDTH-1:0] raddr,
  input  logic [BITS-1:0]   rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BITS-1:0]   out_data,
  output logic              out_last
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state_reg, state_next;
  logic [AWIDTH-1:0] raddr_reg;
  logic [AWIDTH:0]   remain_reg;          // reads still to be issued
  logic              in_flight_reg;       // read issued last edge, data on rdata now
  logic              in_flight_last_reg;  // that read is the final word
  logic [BITS-1:0]   fifo_data_reg [2];
  logic [1:0]        fifo_last_reg;
  logic              wr_ptr_reg, rd_ptr_reg;
  logic [1:0]        count_reg;

  logic       pop, push;
  logic       last_read;
  logic [2:0] occupancy;

  assign out_valid = (count_reg != 2'd0);
  assign pop       = out_valid & out_ready;
  assign push      = in_flight_reg;
  assign out_data  = out_valid ? fifo_data_reg[rd_ptr_reg] : '0;
  assign out_last  = out_valid & fifo_last_reg[rd_ptr_reg];
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign raddr     = raddr_reg;

  // Credit check: a new read may be issued only if, after this cycle's
  // pop, buffered plus in-flight samples leave room for it in the FIFO.
  assign occupancy = {1'b0, count_reg} + {2'b00, in_flight_reg};
  assign re        = (state_reg == RUN) && (remain_reg != '0) &&
                     (occupancy < (3'd2 + {2'b00, pop}));
  assign last_read = (remain_reg == (AWIDTH+1)'(1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (start) state_next = (len == '0) ? DONE : RUN;
      RUN:   if (re && last_read) state_next = DRAIN;
      DRAIN: if (pop && out_last) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_reg          <= IDLE;
      raddr_reg          <= '0;
      remain_reg         <= '0;
      in_flight_reg      <= 1'b0;
      in_flight_last_reg <= 1'b0;
      wr_ptr_reg         <= 1'b0;
      rd_ptr_reg         <= 1'b0;
      count_reg          <= 2'd0;
    end else begin
      state_reg          <= state_next;
      in_flight_reg      <= re;
      in_flight_last_reg <= re & last_read;
      if (state_reg == IDLE && start && len != '0) begin
        raddr_reg  <= base;
        remain_reg <= len;
      end else if (re) begin
        // Natural AWIDTH-bit overflow provides the wrap.
        raddr_reg  <= raddr_reg + 1'b1;
        remain_reg <= remain_reg - 1'b1;
      end
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
    end
  end

  // Two-entry output FIFO: captures rdata on the edge after the read's
  // data became valid, together with its last-sample flag.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
    always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
        fifo_data_reg[gi] <= '0;
        fifo_last_reg[gi] <= 1'b0;
      end else if (push && wr_ptr_reg == 1'(gi)) begin
        fifo_data_reg[gi] <= rdata;
        fifo_last_reg[gi] <= in_flight_last_reg;
      end
    end
  end

endmodule

// File: tb/tb_dpram_reader.sv
// Testbench for dpram_reader: table of directed commands with constant
// expectations, a reset-abort sequence and randomized commands checked
// against a sample-order model (ram[(base+n) mod SIZE]).
module tb_dpram_reader;
  localparam int BITS   = 16;
  localparam int SIZE   = 256;
  localparam int AWIDTH = 8;

  logic              ck = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [AWIDTH-1:0] base = '0;
  logic [AWIDTH:0]   len = '0;
  logic              busy, done, re;
  logic [AWIDTH-1:0] raddr;
  logic [BITS-1:0]   rdata = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [BITS-1:0]   out_data;
  logic              out_last;

  dpram_reader #(.BITS(BITS), .SIZE(SIZE), .AWIDTH(AWIDTH)) dut (
    .ck(ck), .rst_n(rst_n), .start(start), .base(base), .len(len),
    .busy(busy), .done(done), .re(re), .raddr(raddr), .rdata(rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last)
  );

  always #5 ck = ~ck;

  // Behavioural dpram: one-cycle registered read.
  logic [BITS-1:0]   ram [SIZE];
  logic              re_s = 1'b0;
  logic [AWIDTH-1:0] raddr_s = '0;
  always @(posedge ck) if (re_s) rdata <= ram[raddr_s];

  // Monitor state (written only by the monitor process).
  logic [BITS-1:0] got_data[$];
  bit              got_last[$];
  int              raddr_log[$];
  int issued, xfer, done_cnt, occ_err, stab_err, valid_seen;
  int cyc = 0, start_cyc, done_cyc, fv_cyc;
  int seen_seq = 0;
  bit hold_pending;
  logic [BITS-1:0] hold_d;
  logic hold_l;

  // Written only by the stimulus process.
  int clear_seq = 0;
  int errors = 0, checks = 0;

  always @(negedge ck) begin
    if (clear_seq != seen_seq) begin
      seen_seq = clear_seq;
      got_data.delete(); got_last.delete(); raddr_log.delete();
      issued = 0; xfer = 0; done_cnt = 0; occ_err = 0; stab_err = 0;
      valid_seen = 0; hold_pending = 0;
      start_cyc = -1; done_cyc = -1; fv_cyc = -1;
    end
    re_s    = re && rst_n;
    raddr_s = raddr;
    cyc++;
    if (!rst_n) begin
      hold_pending = 0;
    end else begin
      if (start && !busy && start_cyc < 0) start_cyc = cyc;
      if (re) begin raddr_log.push_back(int'(raddr)); issued++; end
      if (out_valid) begin valid_seen++; if (fv_cyc < 0) fv_cyc = cyc; end
      if (hold_pending && (!out_valid || out_data !== hold_d || out_last !== hold_l))
        stab_err++;
      hold_pending = out_valid && !out_ready;
      hold_d = out_data;
      hold_l = out_last;
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
        xfer++;
      end
      // Reads issued but not yet handed downstream must never exceed 2.
      if (issued - xfer > 2) occ_err++;
      if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int base;
    int len;
    int pct;          // out_ready probability in percent
    int stall_at;     // first cycle of a forced out_ready=0 window
    int stall_n;      // length of that window
    int restart_at;   // cycle at which a spurious start is pulsed (-1: none)
    int exp_first;    // expected first sample (-1: unchecked)
    int exp_last;     // expected last sample (-1: unchecked)
    int exp_done_lat; // cycles from start sample to done (-1: unchecked)
    int exp_fv_lat;   // cycles from start sample to first out_valid (-1: unchecked)
  } vec_t;

  task automatic run_cmd(input vec_t v, input string tag);
    int bad;
    bit finished;
    clear_seq++;
    @(posedge ck); #1;
    base      = AWIDTH'(v.base);
    len       = (AWIDTH+1)'(v.len);
    start     = 1'b1;
    out_ready = ($urandom_range(99) < v.pct);
    finished  = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge ck); #1;
      start = 1'b0;
      if (c == v.restart_at) begin
        start = 1'b1; base = '0; len = (AWIDTH+1)'(3);
      end
      if (c >= v.stall_at && c < v.stall_at + v.stall_n) out_ready = 1'b0;
      else out_ready = ($urandom_range(99) < v.pct);
      if (done_cnt != 0 && !busy) begin finished = 1; break; end
    end
    start = 1'b0;
    repeat (3) @(posedge ck);
    chk({tag, " completes"}, finished, 1);
    chk({tag, " count"}, got_data.size(), v.len);
    bad = 0;
    for (int i = 0; i < got_data.size(); i++)
      if (got_data[i] !== ram[(v.base + i) % SIZE] || got_last[i] != (i == v.len - 1)) bad++;
    chk({tag, " sample_mismatches"}, bad, 0);
    chk({tag, " reads_issued"}, raddr_log.size(), v.len);
    bad = 0;
    for (int i = 0; i < raddr_log.size(); i++)
      if (raddr_log[i] != (v.base + i) % SIZE) bad++;
    chk({tag, " raddr_mismatches"}, bad, 0);
    chk({tag, " done_pulses"}, done_cnt, 1);
    chk({tag, " occupancy_violations"}, occ_err, 0);
    chk({tag, " stall_instability"}, stab_err, 0);
    if (v.len == 0) chk({tag, " valid_cycles"}, valid_seen, 0);
    if (v.exp_first >= 0 && got_data.size() > 0) chk({tag, " first_sample"}, got_data[0], v.exp_first);
    if (v.exp_last >= 0 && got_data.size() > 0) chk({tag, " last_sample"}, got_data[got_data.size()-1], v.exp_last);
    if (v.exp_done_lat >= 0) chk({tag, " done_latency"}, done_cyc - start_cyc, v.exp_done_lat);
    if (v.exp_fv_lat >= 0) chk({tag, " first_valid_latency"}, fv_cyc - start_cyc, v.exp_fv_lat);
    $display("cmd %s base=%0d len=%0d ready%%=%0d samples=%0d done_lat=%0d errors=%0d",
             tag, v.base, v.len, v.pct, got_data.size(), done_cyc - start_cyc, errors);
  endtask

  vec_t vecs[8];
  vec_t rv;

  initial begin
    // ram[a] = 3a for the directed phase
    for (int i = 0; i < SIZE; i++) ram[i] = BITS'(3 * i);

    //           base len pct  stl_at stl_n rst  first last dlat fvlat
    vecs[0] = '{  10,   4, 100,  -1,   0,  -1,   30,  39,   7,  3};
    vecs[1] = '{ 254,   4, 100,  -1,   0,  -1,  762,   3,   7,  3};
    vecs[2] = '{  40,   8,  50,   3,  10,  -1,  120, 141,  -1,  3};
    vecs[3] = '{   0,   0, 100,  -1,   0,  -1,   -1,  -1,   1, -1};
    vecs[4] = '{  20,   6, 100,  -1,   0,   2,   60,  75,   9,  3};
    vecs[5] = '{ 128, 256, 100,  -1,   0,  -1,  384, 381, 259,  3};
    vecs[6] = '{   5,   1, 100,  -1,   0,  -1,   15,  15,   4,  3};
    vecs[7] = '{ 255, 256,  30,  -1,   0,  -1,  765, 762,  -1,  3};

    // Reset state
    repeat (3) @(posedge ck);
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset re", re, 0);
    chk("reset raddr", raddr, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", out_data, 0);
    chk("reset out_last", out_last, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_cmd(vecs[i], $sformatf("vec%0d", i));

    // Reset abort in the middle of a 16-word command
    clear_seq++;
    @(posedge ck); #1;
    base = 8'd50; len = 9'd16; start = 1'b1; out_ready = 1'b1;
    @(posedge ck); #1;
    start = 1'b0;
    repeat (7) @(posedge ck);
    #3;
    chk("abort pre out_valid", out_valid, 1);
    chk("abort pre busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort out_valid", out_valid, 0);
    chk("abort busy", busy, 0);
    chk("abort re", re, 0);
    chk("abort raddr", raddr, 0);
    @(posedge ck); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge ck);
    #1;
    chk("abort no_done", done_cnt, 0);
    chk("abort idle", busy, 0);
    $display("cmd abort base=50 len=16 reset mid-run errors=%0d", errors);
    run_cmd('{50, 16, 100, -1, 0, -1, 150, 195, 19, 3}, "post_abort");

    // Randomized commands on random RAM contents
    for (int i = 0; i < SIZE; i++) ram[i] = BITS'($urandom);
    for (int k = 0; k < 20; k++) begin
      rv.base       = int'($urandom_range(SIZE - 1));
      rv.len        = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(40, 1));
      rv.pct        = int'($urandom_range(100, 20));
      rv.stall_at   = ($urandom_range(3) == 0) ? int'($urandom_range(10)) : -1;
      rv.stall_n    = int'($urandom_range(12));
      rv.restart_at = ($urandom_range(3) == 0) ? int'($urandom_range(5)) : -1;
      rv.exp_first  = -1;
      rv.exp_last   = -1;
      rv.exp_done_lat = -1;
      rv.exp_fv_lat = (rv.len == 0) ? -1 : 3;
      run_cmd(rv, $sformatf("rand%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dpram_reader.md
# dpram_reader

Read-side sequencer for the `dpram` block in the DSP chain. On a start command it walks a contiguous, wrapping address range of a `dpram`, issuing reads and absorbing the RAM's one-cycle read latency. It delivers the samples as a valid/ready stream with full backpressure support and sustains one sample per clock when the sink never stalls. It sits between a sample buffer filled by a writer and the downstream DSP stage: filter, FFT or I2S output.

## Interface
- `BITS`, 16, sample width; must match the `dpram` instance.
- `SIZE`, 256, RAM depth in words; must be a power of two.
- `AWIDTH`, `$clog2(SIZE)`, address width.

- `ck`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  command strobe; sampled only in IDLE.
- `base`  in  AWIDTH  first address; sampled with `start`.
- `len`  in  AWIDTH+1  number of words, 0..SIZE; sampled with `start`.
- `busy`  out  1  high while a command is in progress.
- `done`  out  1  one-cycle pulse at command completion.
- `re`  out  1  read enable to `dpram`.
- `raddr`  out  AWIDTH  read address to `dpram`.
- `rdata`  in  BITS  `dpram` read data; valid the cycle after an edge that sampled `re`=1.
- `out_valid`  out  1  stream data valid.
- `out_ready`  in  1  stream sink ready.
- `out_data`  out  BITS  sample.
- `out_last`  out  1  marks the final sample of the command.

## Operation
- **States:**
  - **IDLE:** waiting for a command.
  - **RUN:** reads outstanding.
  - **DRAIN:** all reads issued, output FIFO not yet empty.
  - **DONE:** single cycle in which `done`=1, then return to IDLE.
- **Start:**
  - IDLE with `start`=1 and `len`≠0 → RUN.
  - IDLE with `start`=1 and `len`=0 → DONE directly; no `re` is issued.
  - `start` is ignored in every state other than IDLE.
- **Address generation:** the n-th read uses `raddr` = (`base` + n) mod SIZE, for n = 0..len-1. Wrap is the natural AWIDTH-bit overflow.
- **Output buffer:** a 2-entry FIFO captures `rdata` on the edge after each read's data becomes valid. A tracked in-flight flag marks the read awaiting capture.
- **Credit rule:** `re`=1 iff state is RUN, reads remain, and (FIFO count + in-flight − pop) < 2, where pop = `out_valid` & `out_ready` this cycle.
  - `re` is combinational from registered state and `out_ready`.
  - `raddr` holds its value when `re`=0.
- **Handshake:**
  - A transfer occurs on an edge where `out_valid` & `out_ready`.
  - `out_data` and `out_last` are stable while `out_valid`=1 and `out_ready`=0.
  - `out_valid` never drops without a transfer, except on reset.
- **`out_last`:** high with the len-th sample only.
- **DRAIN → DONE:** on the transfer of the `out_last` sample.
- **`busy`:** high in RUN, DRAIN and DONE.
- **Sample integrity:** no sample is duplicated or dropped under any `out_ready` pattern. Samples are emitted in address order.

## Timing
- **Reset values:** `busy`=0, `done`=0, `re`=0, `raddr`=0, `out_valid`=0, `out_data`=0, `out_last`=0; state IDLE, FIFO empty, in-flight cleared.
- **Start latency:** let `start` be sampled at edge E0.
  - `re`=1 during the cycle after E0.
  - `rdata` is valid after E1.
  - First `out_valid`=1 after E2.
- **Throughput:** with `out_ready` held at 1, one sample per cycle. For a command of `len`=L, the last transfer occurs at edge E(L+2), `done`=1 in the following cycle, and IDLE is re-entered after E(L+3).
- **Back-to-back commands:** the earliest next `start` is sampled in the cycle after `done`.
- **Reset mid-operation:** asynchronous abort. All outputs take their reset values immediately; no `done` is generated; buffered samples are discarded.
- **Maximum length:** `len`=SIZE reads every word exactly once, starting at `base`.

## Test plan
- Basic read: ram[a]=3·a, `base`=10, `len`=4, `out_ready`=1 → `out_data` 30,33,36,39 on consecutive cycles; `out_last` only with 39; first `out_valid` 3 cycles after `start`; single `done` pulse.
- Wrap: `base`=254, `len`=4, SIZE=256 → `raddr` sequence 254,255,0,1; `out_data` matches ram at those addresses.
- Backpressure: `len`=8, `out_ready` random at 50% and also held low for 10 cycles → exactly 8 samples in order; data stable while stalled; reads outstanding plus buffered never exceed 2.
- Zero length and ignored start: `len`=0 → `done` the next cycle, `re` never asserted, no `out_valid`. A second `start` pulsed during RUN → no effect on the current transfer.
- Full buffer: `len`=256, `base`=128 → 256 samples from addresses 128..255 then 0..127, each exactly once.
- Reset abort: `rst_n` low for 1 cycle midway through `len`=16 → `out_valid`, `busy` and `re` drop immediately; no `done`. A fresh `start` afterwards completes normally.
